// File: rtl/multiplier.sv
// Combinational 8x8 multiplier shared by multiplier_arbiter.
//   A, B : 8-bit operands
//   S    : 1 = operands are two's complement, 0 = unsigned
//   V    : 0 = one 8x8 product in Y[15:0]
//          1 = two independent 4x4 lane products, Y[15:8] = A[7:4]*B[7:4],
//              Y[7:0] = A[3:0]*B[3:0] (each lane signed/unsigned per S)
//   Y    : 16-bit result
module multiplier (
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic        S,
    input  logic        V,
    output logic [15:0] Y
);

    logic [15:0] a_ext;
    logic [15:0] b_ext;
    logic [15:0] full_prod;
    logic [7:0]  a_hi;
    logic [7:0]  b_hi;
    logic [7:0]  a_lo;
    logic [7:0]  b_lo;
    logic [7:0]  hi_prod;
    logic [7:0]  lo_prod;

    // Extending to the result width lets a plain truncated product serve both signednesses.
    always_comb begin
        a_ext     = S ? {{8{A[7]}}, A} : {8'h00, A};
        b_ext     = S ? {{8{B[7]}}, B} : {8'h00, B};
        full_prod = a_ext * b_ext;
        a_hi      = S ? {{4{A[7]}}, A[7:4]} : {4'h0, A[7:4]};
        b_hi      = S ? {{4{B[7]}}, B[7:4]} : {4'h0, B[7:4]};
        a_lo      = S ? {{4{A[3]}}, A[3:0]} : {4'h0, A[3:0]};
        b_lo      = S ? {{4{B[3]}}, B[3:0]} : {4'h0, B[3:0]};
        hi_prod   = a_hi * b_hi;
        lo_prod   = a_lo * b_lo;
        Y         = V ? {hi_prod, lo_prod} : full_prod;
    end

endmodule

// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter sharing one multiplier among NUM_REQ requesters, with a
// registered response channel carrying the result and the requester index.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (ready is combinational, one-hot or zero)
//   req_a/req_b           packed 8-bit operands, requester i in bits [8i+7:8i]
//   req_s/req_v           per-requester multiplier controls
//   rsp_valid/rsp_ready   response handshake
//   rsp_y/rsp_id          registered result and originating requester index
// Build option: define MULTIPLIER_ARBITER_INPUT_REG_EN to insert an operand
// register stage in front of the multiplier (2-cycle latency, same throughput).
module multiplier_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*8-1:0] req_a,
    input  logic [NUM_REQ*8-1:0] req_b,
    input  logic [NUM_REQ-1:0]   req_s,
    input  logic [NUM_REQ-1:0]   req_v,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [15:0]          rsp_y,
    output logic [ID_W-1:0]      rsp_id
);

    localparam int unsigned OP_W  = 8;
    localparam int unsigned RES_W = 16;
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W-1:0] rr_ptr;
    logic             rsp_free_c;
    logic             slot_free_c;
    logic             grant_c;
    logic             found_c;
    logic [IDX_W-1:0] grant_idx_c;
    logic [IDX_W:0]   scan_sum_c;
    logic [IDX_W-1:0] scan_idx_c;
    logic [IDX_W-1:0] sel_idx_c;
    logic [OP_W-1:0]  mux_a_c;
    logic [OP_W-1:0]  mux_b_c;
    logic             mux_s_c;
    logic             mux_v_c;
    logic [OP_W-1:0]  mul_a_c;
    logic [OP_W-1:0]  mul_b_c;
    logic             mul_s_c;
    logic             mul_v_c;
    logic [RES_W-1:0] mul_y_c;

    assign rsp_free_c = !rsp_valid || rsp_ready;

    // First valid requester at or above rr_ptr, wrapping; gated off while in reset.
    always_comb begin
        found_c     = 1'b0;
        grant_idx_c = '0;
        scan_sum_c  = '0;
        scan_idx_c  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_sum_c = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (scan_sum_c >= NUM_REQ_W) begin
                scan_sum_c = scan_sum_c - NUM_REQ_W;
            end
            scan_idx_c = scan_sum_c[IDX_W-1:0];
            if (!found_c && req_valid[scan_idx_c]) begin
                found_c     = 1'b1;
                grant_idx_c = scan_idx_c;
            end
        end
        grant_c = found_c && slot_free_c && rst_n;
    end

    // One-hot ready for the granted requester.
    always_comb begin
        req_ready = '0;
        if (grant_c) begin
            req_ready[grant_idx_c] = 1'b1;
        end
    end

    // Operand select for the requester addressed by sel_idx_c.
    always_comb begin
        mux_a_c = '0;
        mux_b_c = '0;
        mux_s_c = 1'b0;
        mux_v_c = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (sel_idx_c == IDX_W'(i)) begin
                mux_a_c = req_a[i*OP_W +: OP_W];
                mux_b_c = req_b[i*OP_W +: OP_W];
                mux_s_c = req_s[i];
                mux_v_c = req_v[i];
            end
        end
    end

    // Round-robin pointer advances past each granted index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_c) begin
            if (grant_idx_c == IDX_W'(NUM_REQ-1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx_c + IDX_W'(1);
            end
        end
    end

`ifdef MULTIPLIER_ARBITER_INPUT_REG_EN
    logic             op_valid;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic             op_s;
    logic             op_v;
    logic [ID_W-1:0]  op_id;

    // The operand stage may accept whenever it is empty or moving on.
    assign slot_free_c = !op_valid || rsp_free_c;
    assign sel_idx_c   = grant_idx_c;

    assign mul_a_c = op_a;
    assign mul_b_c = op_b;
    assign mul_s_c = op_s;
    assign mul_v_c = op_v;

    // Operand register; holds its last payload when idle so the multiplier input is quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_s     <= 1'b0;
            op_v     <= 1'b0;
            op_id    <= '0;
        end else if (grant_c) begin
            op_valid <= 1'b1;
            op_a     <= mux_a_c;
            op_b     <= mux_b_c;
            op_s     <= mux_s_c;
            op_v     <= mux_v_c;
            op_id    <= ID_W'(grant_idx_c);
        end else if (rsp_free_c) begin
            op_valid <= 1'b0;
        end
    end

    // Response register loads from the operand stage whenever the slot frees up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_id    <= '0;
        end else if (rsp_free_c) begin
            rsp_valid <= op_valid;
            if (op_valid) begin
                rsp_y  <= mul_y_c;
                rsp_id <= op_id;
            end
        end
    end
`else
    logic [IDX_W-1:0] last_idx;

    assign slot_free_c = rsp_free_c;
    // Keep the multiplier on the last granted requester when nothing is granted.
    assign sel_idx_c   = grant_c ? grant_idx_c : last_idx;

    assign mul_a_c = mux_a_c;
    assign mul_b_c = mux_b_c;
    assign mul_s_c = mux_s_c;
    assign mul_v_c = mux_v_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_idx <= '0;
        end else if (grant_c) begin
            last_idx <= grant_idx_c;
        end
    end

    // Response register: load on grant, drain on accept, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_id    <= '0;
        end else if (grant_c) begin
            rsp_valid <= 1'b1;
            rsp_y     <= mul_y_c;
            rsp_id    <= ID_W'(grant_idx_c);
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
`endif

    multiplier u_multiplier (
        .A (mul_a_c),
        .B (mul_b_c),
        .S (mul_s_c),
        .V (mul_v_c),
        .Y (mul_y_c)
    );

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Directed and randomized checks for multiplier_arbiter (base build, NUM_REQ=4).
module tb_multiplier_arbiter;

    localparam int N = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*8-1:0]  req_a;
    logic [N*8-1:0]  req_b;
    logic [N-1:0]    req_s;
    logic [N-1:0]    req_v;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [15:0]     rsp_y;
    logic [1:0]      rsp_id;

    int checks;
    int failures;

    multiplier_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_s     (req_s),
        .req_v     (req_v),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic s, input logic v);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        req_s[i]        = s;
        req_v[i]        = v;
    endtask

    task automatic next_neg();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference product: integer arithmetic on extended operands.
    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                            input logic s, input logic v);
        int pa, pb, ph, pl;
        logic [3:0] ah, al, bh, bl;
        if (!v) begin
            pa = s ? int'($signed(a)) : int'(a);
            pb = s ? int'($signed(b)) : int'(b);
            return 16'(pa * pb);
        end
        ah = a[7:4]; al = a[3:0]; bh = b[7:4]; bl = b[3:0];
        ph = (s ? int'($signed(ah)) : int'(ah)) * (s ? int'($signed(bh)) : int'(bh));
        pl = (s ? int'($signed(al)) : int'(al)) * (s ? int'($signed(bl)) : int'(bl));
        return {8'(ph), 8'(pl)};
    endfunction

    logic [15:0] rr_y_tbl [5];
    int          rr_id_tbl [5];
    logic [7:0]  dv_a [3];
    logic [7:0]  dv_b [3];
    logic        dv_s [3];
    logic        dv_v [3];
    logic [15:0] dv_y [3];

    logic [N-1:0] v;
    logic [7:0]   pa [N];
    logic [7:0]   pb [N];
    logic         ps [N];
    logic         pv [N];
    int           waits [N];
    logic [N-1:0] exp_ready;
    int           g;
    int           idx;
    logic         m_valid;
    logic [15:0]  m_y;
    int           m_id;
    int           m_ptr;

    initial begin
        checks    = 0;
        failures  = 0;
        rr_y_tbl  = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0010};
        rr_id_tbl = '{0, 1, 2, 3, 0};
        dv_a = '{8'hFE, 8'h23, 8'hF2};
        dv_b = '{8'h03, 8'h45, 8'h33};
        dv_s = '{1'b1, 1'b0, 1'b1};
        dv_v = '{1'b0, 1'b1, 1'b1};
        dv_y = '{16'hFFFA, 16'h080F, 16'hFD06};

        // Reset with every requester valid: ready must stay low.
        rst_n     = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        req_a = '0; req_b = '0; req_s = '0; req_v = '0;
        #12;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_y", 32'(rsp_y), 32'h0);
        chk("rst_id", 32'(rsp_id), 32'h0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Idle cycles.
        for (int c = 0; c < 5; c++) begin
            next_neg();
            chk("idle_valid", 32'(rsp_valid), 32'h0);
            chk("idle_ready", 32'(req_ready), 32'h0);
            chk("idle_y", 32'(rsp_y), 32'h0);
        end

        // Single request on index 2.
        set_req(2, 8'h03, 8'h05, 1'b0, 1'b0);
        req_valid = 4'b0100;
        #1 chk("single_ready", 32'(req_ready), 32'h4);
        next_neg();
        chk("single_valid", 32'(rsp_valid), 32'h1);
        chk("single_y", 32'(rsp_y), 32'h000F);
        chk("single_id", 32'(rsp_id), 32'h2);
        req_valid = '0;
        #1 chk("single_ready_off", 32'(req_ready), 32'h0);
        next_neg();
        chk("drain_valid", 32'(rsp_valid), 32'h0);
        chk("drain_y_hold", 32'(rsp_y), 32'h000F);
        chk("drain_id_hold", 32'(rsp_id), 32'h2);

        // Fresh reset, then all four held valid: strict rotation, back-to-back results.
        rst_n = 1'b0;
        #1 chk("rr_rst_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 8'(i + 1), 8'h10, 1'b0, 1'b0);
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1 chk("rr_ready", 32'(req_ready), 32'(1 << rr_id_tbl[k]));
            next_neg();
            chk("rr_valid", 32'(rsp_valid), 32'h1);
            chk("rr_y", 32'(rsp_y), 32'(rr_y_tbl[k]));
            chk("rr_id", 32'(rsp_id), 32'(rr_id_tbl[k]));
        end

        // Backpressure: response held, no grants, then grant on the release cycle.
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        set_req(1, 8'h07, 8'h09, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1 chk("bp_ready", 32'(req_ready), 32'h0);
            next_neg();
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_y", 32'(rsp_y), 32'h0010);
            chk("bp_id", 32'(rsp_id), 32'h0);
        end
        rsp_ready = 1'b1;
        #1 chk("bp_grant", 32'(req_ready), 32'h2);
        next_neg();
        chk("bp_rsp_y", 32'(rsp_y), 32'h003F);
        chk("bp_rsp_id", 32'(rsp_id), 32'h1);
        req_valid = '0;

        // Signed and lane-mode products through requester 0.
        for (int k = 0; k < 3; k++) begin
            set_req(0, dv_a[k], dv_b[k], dv_s[k], dv_v[k]);
            req_valid = 4'b0001;
            #1 chk("mode_ready", 32'(req_ready), 32'h1);
            next_neg();
            chk("mode_y", 32'(rsp_y), 32'(dv_y[k]));
            chk("mode_id", 32'(rsp_id), 32'h0);
            req_valid = '0;
        end
        next_neg();
        chk("pre_rand_valid", 32'(rsp_valid), 32'h0);

        // Randomized traffic against a reference arbiter/multiplier model.
        v       = '0;
        m_valid = 1'b0;
        m_y     = '0;
        m_id    = 0;
        m_ptr   = 1;
        for (int i = 0; i < N; i++) waits[i] = 0;
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 2) != 0) begin
                    pa[i] = 8'($urandom);
                    pb[i] = 8'($urandom);
                    ps[i] = 1'($urandom);
                    pv[i] = 1'($urandom);
                    set_req(i, pa[i], pb[i], ps[i], pv[i]);
                    v[i]     = 1'b1;
                    waits[i] = 0;
                end
            end
            req_valid = v;
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = '0;
            g = -1;
            if (!m_valid || rsp_ready) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (g < 0 && v[idx]) g = idx;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            chk("rand_ready", 32'(req_ready), 32'(exp_ready));
            if (g >= 0) begin
                chk("rand_fair", 32'(waits[g] < N), 32'h1);
                for (int i = 0; i < N; i++) if (i != g && v[i]) waits[i]++;
                m_y     = ref_mul(pa[g], pb[g], ps[g], pv[g]);
                m_id    = g;
                m_valid = 1'b1;
                m_ptr   = (g + 1) % N;
                v[g]    = 1'b0;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
            next_neg();
            chk("rand_valid", 32'(rsp_valid), 32'(m_valid));
            if (m_valid) begin
                chk("rand_y", 32'(rsp_y), 32'(m_y));
                chk("rand_id", 32'(rsp_id), 32'(m_id));
            end
        end

        // Reset while a response is pending: cleared without a clock, pointer back to 0.
        req_valid = '0;
        rsp_ready = 1'b1;
        next_neg();
        set_req(1, 8'h02, 8'h04, 1'b0, 1'b0);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1 chk("mid_ready", 32'(req_ready), 32'h2);
        next_neg();
        chk("mid_valid", 32'(rsp_valid), 32'h1);
        chk("mid_y", 32'(rsp_y), 32'h0008);
        set_req(3, 8'h05, 8'h05, 1'b0, 1'b0);
        req_valid = 4'b1010;
        rsp_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(rsp_valid), 32'h0);
        chk("async_y", 32'(rsp_y), 32'h0);
        chk("async_id", 32'(rsp_id), 32'h0);
        chk("async_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_ready", 32'(req_ready), 32'h2);
        next_neg();
        chk("post_rst_y", 32'(rsp_y), 32'h0008);
        chk("post_rst_id", 32'(rsp_id), 32'h1);
        req_valid = 4'b1000;
        #1 chk("post_rst_next", 32'(req_ready), 32'h8);
        next_neg();
        chk("post_rst_y3", 32'(rsp_y), 32'h0019);
        chk("post_rst_id3", 32'(rsp_id), 32'h3);
        req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiplier_arbiter.md
# multiplier_arbiter

- Shares one combinational 8x8 `multiplier` instance (ports A, B, S, V, Y) between NUM_REQ independent requesters.
- Round-robin arbitration, per-requester valid/ready handshakes and a registered response channel with backpressure.
- The response carries the granted requester's index, so clients can demultiplex results.
- Sits between the operand-producing clients and the multiplier datapath. It is the only block that drives the multiplier's inputs.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of the response id; NUM_REQ <= 2**ID_W
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  NUM_REQ  per-requester operand valid
- req_ready  output  NUM_REQ  per-requester grant/accept, at most one bit high
- req_a  input  NUM_REQ*8  operand A, requester i in bits [8i+7:8i]
- req_b  input  NUM_REQ*8  operand B, same packing
- req_s  input  NUM_REQ  S control per requester, passed to multiplier unchanged
- req_v  input  NUM_REQ  V control per requester, passed to multiplier unchanged
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_y  output  16  multiplier result Y
- rsp_id  output  ID_W  index of requester whose operands produced rsp_y

## Operation
- **Requester rules.** Once req_valid[i] rises, it stays high with a stable payload until req_ready[i] is high in the same cycle (transfer). Requesters must not derive req_valid from req_ready.
- **Slot free.** The response slot is free when rsp_valid==0 or rsp_ready==1.
- **Grant.** When the slot is free and any req_valid is set, exactly one requester is granted.
  - The grant is the first valid index found scanning upward from rr_ptr, wrapping at NUM_REQ-1 -> 0.
  - req_ready[g]=1 combinationally for the granted index g. All other ready bits are 0.
- **Datapath.** The multiplier is driven from the granted requester's A/B/S/V. When no grant is made, it is driven with the last granted operands; the result is don't-care.
- **On transfer at index g:**
  - rsp_y <= multiplier Y.
  - rsp_id <= g.
  - rsp_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
- **Pointer hold.** rr_ptr holds when no grant is made.
- **Response drain.** If rsp_valid && rsp_ready and no new grant, rsp_valid <= 0. rsp_y and rsp_id hold their last values.
- **Stall.** If rsp_valid && !rsp_ready, all req_ready are 0 and rsp_y/rsp_id are held stable.
- **Fairness.** A continuously valid requester is granted within NUM_REQ consecutive grants.
- **Simultaneous drain and grant.** A drain and a grant in the same cycle keeps rsp_valid=1 and replaces the payload. Throughput is one result per cycle.
- **Reset mid-operation.** Any pending response is discarded. No transfer is lost on the requester side, because ready is 0 during reset.

## Timing
- **Reset values:**
  - rsp_valid=0, rsp_y=16'h0000, rsp_id=0, rr_ptr=0.
  - req_ready all 0 while rst_n==0.
- **Reset timing.** Assertion clears state immediately, with no clock required. The first grant can occur in the first cycle after rst_n deasserts.
- **Latency.** A transfer in cycle N gives rsp_valid=1 with the result in cycle N+1 (base build).
- **Combinational paths.** req_valid->req_ready and rsp_ready->req_ready are combinational. Everything else is registered.

## Configuration
- **Macro:** MULTIPLIER_ARBITER_INPUT_REG_EN.
- **Defined:**
  - An operand register stage (op_valid, A, B, S, V, id) sits between the arbiter and the multiplier.
  - The slot-free condition applies to the operand stage: free when op_valid==0, or when the response slot is free.
  - Latency from transfer to rsp_valid is 2 cycles. Throughput remains 1 per cycle.
  - op_valid resets to 0.
  - The fairness and ordering rules are unchanged.
- **Undefined:** latency is 1 cycle and there is no operand register.

## Test plan
- Reset, then req_valid=0 for 5 cycles -> rsp_valid stays 0, req_ready=0, rsp_y=16'h0000.
- Single request: req 2 with A=8'h03, B=8'h05, S=0, V=0, rsp_ready=1 -> req_ready[2] high for one cycle; next cycle rsp_valid=1, rsp_y=16'h000F, rsp_id=2.
- All four requesters held valid with A=i+1, B=8'h10, rsp_ready=1 -> grants in order 0,1,2,3,0; results 16'h0010, 0020, 0030, 0040, 0010, with back-to-back rsp_valid.
- Backpressure: rsp_ready=0 for 3 cycles with req 1 valid -> rsp_y/rsp_id stable and req_ready=0; when rsp_ready rises, req 1 is granted that cycle.
- Random A/B/S/V on all requesters for 200 cycles with random rsp_ready -> every rsp_y equals a standalone multiplier's output for the recorded operands of rsp_id, and no requester waits more than NUM_REQ grants.
- rst_n pulsed low while rsp_valid=1 -> rsp_valid drops immediately without a clock edge, and rr_ptr=0 (next grant goes to the lowest valid index).
